// File: rtl/systolic_job_sequencer.sv
// rtl/systolic_job_sequencer.sv - sequencer feeding one 2x2 matrix job through a systolic array
// Latches operands, skews them onto the array edges for four cycles, then captures and holds the result.
module systolic_job_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a_in,
    input  logic [15:0] b_in,
    output logic [3:0]  a1,
    output logic [3:0]  a2,
    output logic [3:0]  b1,
    output logic [3:0]  b2,
    output logic        initialize,
    input  logic [8:0]  c1,
    input  logic [8:0]  c2,
    input  logic [8:0]  c3,
    input  logic [8:0]  c4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [35:0] c_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FEED    = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  cnt;
    logic [15:0] a_q;
    logic [15:0] b_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = FEED;
                end
            end
            FEED: begin
                if (cnt == 2'd3) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch, feed counter and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 2'd0;
            a_q   <= 16'd0;
            b_q   <= 16'd0;
            c_out <= 36'd0;
        end else begin
            if (state == IDLE && in_valid) begin
                a_q <= a_in;
                b_q <= b_in;
                cnt <= 2'd0;
            end else if (state == FEED) begin
                cnt <= cnt + 2'd1;
            end
            if (state == CAPTURE) begin
                c_out <= {c4, c3, c2, c1};
            end
        end
    end

    // Skewed lane schedule; lanes idle at zero so spare cycles add nothing to the accumulators
    always_comb begin
        a1         = 4'd0;
        a2         = 4'd0;
        b1         = 4'd0;
        b2         = 4'd0;
        initialize = 1'b0;
        if (state == FEED) begin
            case (cnt)
                2'd0: begin
                    a1         = a_q[3:0];
                    b1         = b_q[3:0];
                    initialize = 1'b1;
                end
                2'd1: begin
                    a1 = a_q[7:4];
                    b1 = b_q[11:8];
                    a2 = a_q[11:8];
                    b2 = b_q[7:4];
                end
                2'd2: begin
                    a2 = a_q[15:12];
                    b2 = b_q[15:12];
                end
                default: begin
                    a1 = 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_job_sequencer.sv
// tb/tb_systolic_job_sequencer.sv - self-checking bench for systolic_job_sequencer
// A behavioural 2x2 systolic array closes the loop; results are checked against a plain matrix product.
module tb_systolic_job_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic [3:0]  a1, a2, b1, b2;
    logic        initialize;
    logic [8:0]  c1, c2, c3, c4;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] c_out;
    logic        busy;

    int passed = 0;
    int total  = 0;

    systolic_job_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a_in       (a_in),
        .b_in       (b_in),
        .a1         (a1),
        .a2         (a2),
        .b1         (b1),
        .b2         (b2),
        .initialize (initialize),
        .c1         (c1),
        .c2         (c2),
        .c3         (c3),
        .c4         (c4),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .c_out      (c_out),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Array: A flows right, B flows down, one register per hop; never reset so stale sums must be cleared by initialize
    logic [3:0] a_right = '0;
    logic [3:0] a_right2 = '0;
    logic [3:0] b_down = '0;
    logic [3:0] b_down2 = '0;
    logic [8:0] acc11 = '0;
    logic [8:0] acc12 = '0;
    logic [8:0] acc21 = '0;
    logic [8:0] acc22 = '0;

    always @(posedge clk) begin
        a_right  <= a1;
        a_right2 <= a2;
        b_down   <= b1;
        b_down2  <= b2;
        acc11 <= (initialize ? 9'd0 : acc11) + 9'(a1) * 9'(b1);
        acc12 <= (initialize ? 9'd0 : acc12) + 9'(a_right) * 9'(b2);
        acc21 <= (initialize ? 9'd0 : acc21) + 9'(a2) * 9'(b_down);
        acc22 <= (initialize ? 9'd0 : acc22) + 9'(a_right2) * 9'(b_down2);
    end

    assign c1 = acc11;
    assign c2 = acc12;
    assign c3 = acc21;
    assign c4 = acc22;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [35:0] matmul(input logic [15:0] a, input logic [15:0] b);
        int m11, m12, m21, m22, n11, n12, n21, n22;
        int r11, r12, r21, r22;
        m11 = a[3:0];  m12 = a[7:4];  m21 = a[11:8];  m22 = a[15:12];
        n11 = b[3:0];  n12 = b[7:4];  n21 = b[11:8];  n22 = b[15:12];
        r11 = m11 * n11 + m12 * n21;
        r12 = m11 * n12 + m12 * n22;
        r21 = m21 * n11 + m22 * n21;
        r22 = m21 * n12 + m22 * n22;
        return {9'(r22), 9'(r21), 9'(r12), 9'(r11)};
    endfunction

    // Expected {initialize, a1, a2, b1, b2} for feed step s (s=4 is the capture cycle)
    function automatic logic [16:0] exp_lanes(input int s, input logic [15:0] a, input logic [15:0] b);
        case (s)
            0:       return {1'b1, a[3:0], 4'd0, b[3:0], 4'd0};
            1:       return {1'b0, a[7:4], a[11:8], b[11:8], b[7:4]};
            2:       return {1'b0, 4'd0, a[15:12], 4'd0, b[15:12]};
            default: return 17'd0;
        endcase
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again
    task automatic run_job(input string name, input logic [15:0] a, input logic [15:0] b, input int hold_cycles);
        logic [35:0] expc;
        expc = matmul(a, b);
        check({name, "_ready"}, 64'(in_ready), 64'd1);
        a_in     = a;
        b_in     = b;
        in_valid = 1'b1;
        @(posedge clk);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            a_in      = 16'($urandom);
            b_in      = 16'($urandom);
            out_ready = (s < 4) ? 1'($urandom) : 1'b0;
            check($sformatf("%s_lanes_s%0d", name, s), 64'({initialize, a1, a2, b1, b2}), 64'(exp_lanes(s, a, b)));
            check($sformatf("%s_busy_s%0d", name, s), 64'({busy, in_ready, out_valid}), 64'b100);
        end
        @(negedge clk);
        check({name, "_latency"}, 64'(out_valid), 64'd1);
        check({name, "_c_out"}, 64'(c_out), 64'(expc));
        for (int h = 0; h < hold_cycles; h++) begin
            @(negedge clk);
            check($sformatf("%s_hold%0d", name, h), 64'({out_valid, in_ready, c_out}), {26'd0, 2'b10, expc});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_release"}, 64'({in_ready, out_valid, busy}), 64'b100);
    endtask

    initial begin
        logic [15:0] ra, rb;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a_in      = 16'd0;
        b_in      = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_c_out", 64'(c_out), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_lanes", 64'({initialize, a1, a2, b1, b2}), 64'd0);
        check("post_reset_ready", 64'({in_ready, busy}), 64'b10);

        run_job("identity", 16'h1001, 16'h6543, 0);
        check("identity_value", 64'(c_out), {28'd0, 9'd6, 9'd5, 9'd4, 9'd3});
        run_job("b2b_first", 16'h4321, 16'h8765, 0);
        check("b2b_first_value", 64'(c_out), {28'd0, 9'd50, 9'd43, 9'd22, 9'd19});
        run_job("b2b_second", 16'h2002, 16'h8765, 0);
        check("b2b_second_value", 64'(c_out), {28'd0, 9'd16, 9'd14, 9'd12, 9'd10});
        run_job("max_backpressure", 16'hFFFF, 16'hFFFF, 10);
        check("max_value", 64'(c_out), {28'd0, 9'd450, 9'd450, 9'd450, 9'd450});

        // Abort during feed step cnt2, then the next job must be clean
        a_in     = 16'h9876;
        b_in     = 16'h5432;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_at_cnt2_lanes", 64'({a1, a2, b1, b2}), 64'(exp_lanes(2, 16'h9876, 16'h5432)) & 64'hFFFF);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_lanes", 64'({initialize, a1, a2, b1, b2}), 64'd0);
        check("abort_flags", 64'({in_ready, out_valid, busy}), 64'b100);
        run_job("after_abort", 16'h1111, 16'h1111, 1);
        check("after_abort_value", 64'(c_out), {28'd0, 9'd2, 9'd2, 9'd2, 9'd2});

        for (int j = 0; j < 8; j++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            run_job($sformatf("rand%0d", j), ra, rb, $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/systolic_job_sequencer.md
SYSTOLIC_JOB_SEQUENCER -- requirements
Module: systolic_job_sequencer

Interface
REQ-001 SHALL have no parameters; data widths are fixed (4-bit operands, 9-bit results).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 in_valid  in  1  job request; A and B operands are valid.
REQ-005 in_ready  out  1  sequencer can accept a job.
REQ-006 a_in  in  16  matrix A: a11 [3:0], a12 [7:4], a21 [11:8], a22 [15:12], unsigned.
REQ-007 b_in  in  16  matrix B: b11 [3:0], b12 [7:4], b21 [11:8], b22 [15:12], unsigned.
REQ-008 a1, a2  out  4 each  row-1 and row-2 A lanes into the 2x2 systolic array (left edge).
REQ-009 b1, b2  out  4 each  column-1 and column-2 B lanes into the array (top edge).
REQ-010 initialize  out  1  one-cycle accumulator clear to the array.
REQ-011 c1, c2, c3, c4  in  9 each  array results c11, c12, c21, c22.
REQ-012 out_valid  out  1  captured result is available.
REQ-013 out_ready  in  1  consumer accepts the result.
REQ-014 c_out  out  36  result: c11 [8:0], c12 [17:9], c21 [26:18], c22 [35:27].
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, FEED, CAPTURE and HOLD; FEED uses a 2-bit counter cnt.
REQ-017 IDLE: in_ready=1; in_valid&in_ready latches a_in/b_in into internal registers; next state FEED with cnt=0.
REQ-018 FEED SHALL last exactly 4 cycles (cnt 0..3), then go to CAPTURE.
REQ-019 FEED lane schedule (unlisted lanes = 0): cnt0: a1=a11, b1=b11, initialize=1; cnt1: a1=a12, b1=b21, a2=a21, b2=b12; cnt2: a2=a22, b2=b22; cnt3: all lanes 0.
REQ-020 initialize SHALL be high only in FEED cnt0.
REQ-021 a1/a2/b1/b2 SHALL be 0 in every state and cycle not listed in REQ-019, so idle cycles add 0 to the array accumulators.
REQ-022 Lane outputs SHALL decode from registered state, cnt and the latched operands only; there is no combinational path from any input.
REQ-023 CAPTURE (1 cycle) SHALL register c1..c4 into c_out; next state HOLD.
REQ-024 HOLD: out_valid=1; c_out stable; out_ready=1 -> IDLE next cycle; out_ready=0 -> remain in HOLD.
REQ-025 Latency: the accept cycle is k; FEED runs k+1..k+4; CAPTURE is k+5; out_valid=1 from k+6.
REQ-026 in_valid outside IDLE SHALL be ignored (in_ready=0); out_ready outside HOLD SHALL be ignored.
REQ-027 The sequencer SHALL NOT accept a new job while a result is held; the earliest re-accept is the cycle after the out_ready handshake.
REQ-028 SHALL perform no arithmetic; c_out is the array value sampled unmodified (max 450 fits 9 bits).

Reset
REQ-029 While rst=1 at a clock edge: state=IDLE, cnt=0, latched operands=0, c_out=0, out_valid=0.
REQ-030 In the cycle after reset, all lanes and initialize SHALL be 0 and in_ready=1.
REQ-031 A reset mid-FEED, CAPTURE or HOLD SHALL abort the job with no output handshake.
REQ-032 The next job after a reset SHALL produce a correct result, because its initialize clears any partial sums.

Verification
REQ-033 Identity: A=[[1,0],[0,1]], B=[[3,4],[5,6]] -> c_out=(3,4,5,6); out_valid rises exactly at accept+6.
REQ-034 Max operands: all elements 15 -> c11=c12=c21=c22=450.
REQ-035 Backpressure: out_ready=0 for 10 cycles -> out_valid=1, c_out constant, in_ready=0; after the out_ready pulse, in_ready=1 on the next cycle.
REQ-036 Back-to-back: A=[[1,2],[3,4]], B=[[5,6],[7,8]] -> (19,22,43,50); then A=[[2,0],[0,2]] with the same B -> (10,12,14,16), showing no carry-over.
REQ-037 Reset at FEED cnt2 -> next cycle lanes=0, in_ready=1, out_valid=0; the following job with A=B=[[1,1],[1,1]] -> (2,2,2,2).
REQ-038 Lane trace: per-cycle a1/a2/b1/b2/initialize match REQ-019 exactly, with operand values 1..8 distinct per element.
